button_debouncer: RTL

//   Conditions one raw push-button input from the board pin into a clean, glitch-free level.

---
 rtl/button_debouncer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizer, stability counter and FSM producing a clean
// level, single-cycle edge strobes and a wrapping press counter.
//
//   state        | meaning
//   S_LOW        | released, level 0
//   S_PEND_HIGH  | synced input went high, qualifying the press
//   S_HIGH       | pressed, level 1
//   S_PEND_LOW   | synced input went low, qualifying the release
module button_debouncer #(
  parameter int STABLE_CYCLES = 250000,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_LOW    = 0,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_in,
  output logic               btn_level,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             PIN_INV  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_PEND_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_level_nxt;

  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [COUNT_W-1:0]     r_count;

  // Synchronizer resets to the idle pin level so a held button is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{PIN_INV}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ PIN_INV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_s) begin
          w_state_nxt = S_PEND_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      S_PEND_HIGH: begin
        if (!w_s) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!w_s) begin
          w_state_nxt = S_PEND_LOW;
          w_cnt_nxt   = '0;
        end
      end
      S_PEND_LOW: begin
        if (w_s) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign w_level_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_PEND_LOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_count <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      if (w_rise_nxt) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign btn_level   = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign press_count = r_count;

endmodule
